// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode map,
// branch condition codes and write-back source encodings.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b1000;
   localparam logic [3:0] OP_STORE = 4'b1001;
   localparam logic [3:0] OP_BCOND = 4'b1010;
   localparam logic [3:0] OP_JUMP  = 4'b1011;
   localparam logic [3:0] OP_PUSH  = 4'b1100;
   localparam logic [3:0] OP_POP   = 4'b1101;
   localparam logic [3:0] OP_CALL  = 4'b1110;
   localparam logic [3:0] OP_SYS   = 4'b1111;

   // Sub-ops of OP_SYS, selected by f1
   localparam logic [1:0] SYS_RET  = 2'b00;
   localparam logic [1:0] SYS_NOP  = 2'b01;
   localparam logic [1:0] SYS_HALT = 2'b10;
   localparam logic [1:0] SYS_ILL  = 2'b11;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_N      = 2'b10;
   localparam logic [1:0] COND_NZ     = 2'b11;

   localparam logic [1:0] MUXPP_ALU  = 2'b00;
   localparam logic [1:0] MUXPP_MEM  = 2'b01;
   localparam logic [1:0] MUXPP_LINK = 2'b10;
   localparam logic [1:0] MUXPP_SP   = 2'b11;

   function automatic logic cond_taken(input logic [1:0] cond, input logic z, input logic n);
      logic taken;
      case (cond)
         COND_ALWAYS: taken = 1'b1;
         COND_Z:      taken = z;
         COND_N:      taken = n;
         default:     taken = ~z;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ctrl_stack_tracker.sv
// Stack occupancy counter; saturates at 0 and DEPTH so it never wraps.
module ctrl_stack_tracker #(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         inc,
   input  logic                         dec,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty
);

   localparam int W = $clog2(DEPTH + 1);

   assign full  = (depth == W'(DEPTH));
   assign empty = (depth == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         depth <= '0;
      end else if (inc && !dec && !full) begin
         depth <= depth + 1'b1;
      end else if (dec && !inc && !empty) begin
         depth <= depth - 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory-ready handshake,
// stack-depth tracking, access timeout and absorbing HALT/FAULT states.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int OPC_W       = 4,
   parameter int FUNC_W      = 2,
   parameter int ALUOP_W     = 3,
   parameter int STACK_DEPTH = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [OPC_W-1:0]                   ir_op,
   input  logic [FUNC_W-1:0]                  ir_f1,
   input  logic [FUNC_W-1:0]                  ir_f2,
   input  logic                               flag_z,
   input  logic                               flag_n,
   input  logic                               mem_ready,
   output logic                               ir_load,
   output logic                               pc_write,
   output logic [ALUOP_W-1:0]                 alu_op,
   output logic                               mem_en,
   output logic                               mem_write,
   output logic                               reg_load,
   output logic                               branch,
   output logic [1:0]                         mux_pp,
   output logic                               mux_push,
   output logic                               mux_return,
   output logic                               is_cond,
   output logic                               is_load,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_depth,
   output logic                               halted,
   output logic                               fault
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       op_q;
   logic [1:0]       f1_q;
   logic             stk_full, stk_empty, stk_inc, stk_dec;

   // Only the top opcode bits and the low two f1 bits take part in decode
   logic unused_ir;
   assign unused_ir = ^{ir_op, ir_f1, ir_f2};

   logic op_alu, op_sys_ret, op_push_like, op_pop_like, op_mem_wb;
   assign op_alu       = ~op_q[3];
   assign op_sys_ret   = (op_q == OP_SYS) && (f1_q == SYS_RET);
   assign op_push_like = (op_q == OP_PUSH) || (op_q == OP_CALL);
   assign op_pop_like  = (op_q == OP_POP) || op_sys_ret;
   assign op_mem_wb    = (op_q == OP_LOAD) || (op_q == OP_POP);

   assign stk_inc = (state == S_MEM) && mem_ready && op_push_like;
   assign stk_dec = ((state == S_MEM) && mem_ready && op_sys_ret) ||
                    ((state == S_WB) && (op_q == OP_POP));

   ctrl_stack_tracker #(.DEPTH(STACK_DEPTH)) u_stack (
      .clk   (clk),
      .reset (reset),
      .inc   (stk_inc),
      .dec   (stk_dec),
      .depth (sp_depth),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         op_q     <= '0;
         f1_q     <= '0;
      end else begin
         case (state)
            S_FETCH, S_MEM: begin
               if (mem_ready) begin
                  wait_cnt <= '0;
                  if (state == S_FETCH) begin
                     op_q  <= ir_op[OPC_W-1 -: 4];
                     f1_q  <= ir_f1[1:0];
                     state <= S_DECODE;
                  end else begin
                     state <= op_mem_wb ? S_WB : S_FETCH;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            // Stack bounds and illegal opcodes are trapped before any memory access
            S_DECODE: begin
               if (((op_q == OP_SYS) && (f1_q == SYS_ILL)) ||
                   (op_push_like && stk_full) || (op_pop_like && stk_empty))
                  state <= S_FAULT;
               else
                  state <= S_EXEC;
            end
            S_EXEC: begin
               if (op_alu)
                  state <= S_WB;
               else if (op_q == OP_BCOND || op_q == OP_JUMP)
                  state <= S_FETCH;
               else if (op_q == OP_SYS)
                  state <= op_sys_ret ? S_MEM : ((f1_q == SYS_HALT) ? S_HALT : S_FETCH);
               else
                  state <= S_MEM;
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_FAULT;
         endcase
      end
   end

   always_comb begin
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      alu_op     = '0;
      mem_en     = 1'b0;
      mem_write  = 1'b0;
      reg_load   = 1'b0;
      branch     = 1'b0;
      mux_pp     = MUXPP_ALU;
      mux_push   = 1'b0;
      mux_return = 1'b0;
      is_cond    = 1'b0;
      is_load    = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_en   = 1'b1;
            ir_load  = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC: begin
            if (op_alu) alu_op = ALUOP_W'(op_q[2:0]);
            if (op_q == OP_BCOND) begin
               is_cond  = 1'b1;
               branch   = cond_taken(f1_q, flag_z, flag_n);
               pc_write = branch;
            end
            if (op_q == OP_JUMP) begin
               branch   = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_MEM: begin
            mem_en    = 1'b1;
            mem_write = (op_q == OP_STORE) || op_push_like;
            mux_push  = op_push_like || op_pop_like;
            is_load   = op_mem_wb;
            if (op_q == OP_CALL) begin
               mux_pp   = MUXPP_LINK;
               branch   = mem_ready;
               pc_write = mem_ready;
            end
            if (op_sys_ret) begin
               mux_return = mem_ready;
               pc_write   = mem_ready;
            end
         end
         S_WB: begin
            reg_load = 1'b1;
            mux_pp   = op_mem_wb ? MUXPP_MEM : MUXPP_ALU;
            is_load  = op_mem_wb;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences with hand-computed outputs.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ir_op;
   logic [1:0] ir_f1, ir_f2;
   logic       flag_z, flag_n, mem_ready;
   logic       ir_load, pc_write, mem_en, mem_write, reg_load, branch;
   logic [2:0] alu_op;
   logic [1:0] mux_pp;
   logic       mux_push, mux_return, is_cond, is_load, halted, fault;
   logic [4:0] sp_depth;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .ir_op(ir_op), .ir_f1(ir_f1), .ir_f2(ir_f2),
      .flag_z(flag_z), .flag_n(flag_n), .mem_ready(mem_ready),
      .ir_load(ir_load), .pc_write(pc_write), .alu_op(alu_op), .mem_en(mem_en),
      .mem_write(mem_write), .reg_load(reg_load), .branch(branch), .mux_pp(mux_pp),
      .mux_push(mux_push), .mux_return(mux_return), .is_cond(is_cond), .is_load(is_load),
      .sp_depth(sp_depth), .halted(halted), .fault(fault)
   );

   // {ir_load, pc_write, alu_op[2:0], mem_en, mem_write, reg_load, branch,
   //  mux_pp[1:0], mux_push, mux_return, is_cond, is_load, halted, fault}
   logic [16:0] outs;
   assign outs = {ir_load, pc_write, alu_op, mem_en, mem_write, reg_load, branch,
                  mux_pp, mux_push, mux_return, is_cond, is_load, halted, fault};

   localparam logic [16:0] O_NONE  = 17'h00000;
   localparam logic [16:0] O_FAULT = 17'h00001;
   localparam logic [16:0] O_HALT  = 17'h00002;
   localparam logic [16:0] O_FWAIT = 17'h00800;
   localparam logic [16:0] O_FACC  = 17'h18800;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; ir_op = '0; ir_f1 = '0; ir_f2 = '0;
      flag_z = 1'b0; flag_n = 1'b0;
      step; step;
      chk("rst_outs", outs, O_FWAIT);
      chk("rst_depth", sp_depth, 0);

      // ALU 0101
      reset = 1'b0; ir_op = 4'b0101; mem_ready = 1'b1; settle;
      chk("alu_fetch", outs, O_FACC);
      step; chk("alu_decode", outs, O_NONE);
      step; chk("alu_exec_op", alu_op, 3'b101); chk("alu_exec_rl", reg_load, 0);
      step; chk("alu_wb", outs, 17'h00200);
      step; chk("alu_refetch", outs, O_FACC);

      // LOAD with three stalled MEM cycles
      ir_op = 4'b1000; settle;
      chk("ld_fetch", ir_load, 1);
      step; step;
      chk("ld_exec_alu", alu_op, 0); chk("ld_exec_memen", mem_en, 0);
      mem_ready = 1'b0;
      step; chk("ld_mem1", outs, 17'h00804);
      step; chk("ld_mem2", outs, 17'h00804);
      step; chk("ld_mem3", outs, 17'h00804);
      step; mem_ready = 1'b1; settle; chk("ld_mem4", outs, 17'h00804);
      step; chk("ld_wb", outs, 17'h00244);
      step;

      // BCOND on Z: not taken, then taken
      ir_op = 4'b1010; ir_f1 = 2'b01; flag_z = 1'b0; settle;
      step; step; chk("bc_nt", outs, 17'h00008);
      step; flag_z = 1'b1;
      step; step; chk("bc_t", outs, 17'h08108);
      step;

      // CALL then RET
      ir_op = 4'b1110; ir_f1 = 2'b00; settle;
      chk("call_depth0", sp_depth, 0);
      step; step; chk("call_exec", outs, O_NONE);
      step;
      chk("call_mem_en", mem_en, 1); chk("call_mem_wr", mem_write, 1);
      chk("call_push", mux_push, 1); chk("call_branch", branch, 1);
      chk("call_pcw", pc_write, 1);
      step; chk("call_depth1", sp_depth, 1);
      ir_op = 4'b1111; ir_f1 = 2'b00; settle;
      step; step; step; chk("ret_mem", outs, 17'h08830);
      step; chk("ret_depth0", sp_depth, 0);

      // POP on empty stack
      ir_op = 4'b1101; settle;
      step; chk("pop0_decode", outs, O_NONE);
      step; chk("pop0_fault", outs, O_FAULT);
      step; chk("pop0_absorb", outs, O_FAULT);
      reset = 1'b1; step; reset = 1'b0; settle;
      chk("pop0_reset", outs, O_FACC);

      // Fill the stack, then overflow
      ir_op = 4'b1100; settle;
      for (int i = 0; i < 16; i++) begin
         step; step; step;
         chk("push_mem", outs, 17'h00C20);
         step;
         chk("push_depth", sp_depth, i + 1);
      end
      step; chk("push17_decode", outs, O_NONE);
      step; chk("push17_fault", outs, O_FAULT); chk("push17_depth", sp_depth, 16);
      step; chk("push17_no_mem", mem_en, 0);
      reset = 1'b1; step; reset = 1'b0; mem_ready = 1'b0; settle;
      chk("push_reset_depth", sp_depth, 0);

      // Fetch timeout
      for (int i = 0; i < 15; i++) begin
         chk("to_wait", outs, O_FWAIT);
         step;
      end
      chk("to_fault", outs, O_FAULT);

      // Reset in the middle of a stalled PUSH
      reset = 1'b1; step; reset = 1'b0; mem_ready = 1'b1; ir_op = 4'b1100; settle;
      step; step; step; step;
      chk("mid_depth1", sp_depth, 1);
      step; step; mem_ready = 1'b0;
      step; chk("mid_mem", outs, 17'h00C20);
      step; chk("mid_hold", outs, 17'h00C20);
      reset = 1'b1; step; reset = 1'b0; settle;
      chk("mid_reset_outs", outs, O_FWAIT);
      chk("mid_reset_depth", sp_depth, 0);

      // Illegal SYS sub-op
      mem_ready = 1'b1; ir_op = 4'b1111; ir_f1 = 2'b11; settle;
      step; chk("ill_decode", outs, O_NONE);
      step; chk("ill_fault", outs, O_FAULT);
      reset = 1'b1; step; reset = 1'b0; settle;

      // NOP (3 cycles) then HALT
      ir_f1 = 2'b01; settle;
      step; step; chk("nop_exec", outs, O_NONE);
      step; chk("nop_refetch", outs, O_FACC);
      ir_f1 = 2'b10; settle;
      step; step; chk("halt_exec", outs, O_NONE);
      step; chk("halt_state", outs, O_HALT);
      mem_ready = 1'b0;
      step; step; chk("halt_absorb", outs, O_HALT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
